// File: rtl/uart_mmio.sv
// Register-mapped byte FIFO pair sitting between a simple bus and a UART transmitter/receiver.
// Latency: read data registered, bus_rvalid one cycle after the request; FIFO state updates at the next clock edge.
// Backpressure: bus never stalls (full TX drops and flags, empty RX returns 0x100); tx_valid/rx_ready follow FIFO occupancy.

// Generic single-clock FIFO; push ignored when full, pop ignored when empty (both judged on the pre-edge count).
// Latency: head_dat is combinational from storage, count/flags update one cycle after push/pop.
// Backpressure: caller observes full/empty; refused operations leave the state untouched.
module sync_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign head_dat = mem[rd_ptr];

    // Storage write; contents are never reset because stale entries are never observed.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

module uart_mmio #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_valid,
    input  logic        bus_write,
    input  logic [3:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic        bus_rvalid,
    output logic [31:0] bus_rdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_CTRL   = 4'h8;
    localparam logic [3:0] ADDR_LEVEL  = 4'hC;

    logic          rd_req;
    logic          wr_req;
    logic          tx_push;
    logic          tx_pop;
    logic          rx_push;
    logic          rx_pop;
    logic          tx_full;
    logic          tx_empty;
    logic          rx_full;
    logic          rx_empty;
    logic [CW-1:0] tx_count;
    logic [CW-1:0] rx_count;
    logic [7:0]    rx_head;
    logic [7:0]    tx_lvl;
    logic [7:0]    rx_lvl;
    logic          tx_ovf;
    logic          rx_ovf;
    logic          tx_ovf_set;
    logic          rx_ovf_set;
    logic          ovf_clr_wr;
    logic          rx_irq_en;
    logic          txe_irq_en;
    logic [31:0]   rd_mux;
    logic          unused_wdata;

    assign rd_req = bus_valid & ~bus_write;
    assign wr_req = bus_valid &  bus_write;

    // Bus-side FIFO requests; the FIFOs themselves refuse a push when full or a pop when empty.
    assign tx_push = wr_req & (bus_addr == ADDR_DATA);
    assign tx_pop  = tx_valid & tx_ready;
    assign rx_push = rx_valid & rx_ready;
    assign rx_pop  = rd_req & (bus_addr == ADDR_DATA) & ~rx_empty;

    // Overflow events are judged on the pre-edge full flags, so a same-cycle pop never rescues a push.
    assign tx_ovf_set = tx_push & tx_full;
    assign rx_ovf_set = rx_valid & rx_full;
    assign ovf_clr_wr = wr_req & (bus_addr == ADDR_STATUS);

    assign tx_valid = ~tx_empty;
    assign rx_ready = ~rx_full;
    assign irq      = (rx_irq_en & ~rx_empty) | (txe_irq_en & tx_empty);

    assign tx_lvl = 8'(tx_count);
    assign rx_lvl = 8'(rx_count);

    assign unused_wdata = &{1'b0, bus_wdata[31:8]};

    sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (tx_push),
        .push_dat (bus_wdata[7:0]),
        .pop      (tx_pop),
        .head_dat (tx_data),
        .count    (tx_count),
        .full     (tx_full),
        .empty    (tx_empty)
    );

    sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rx_push),
        .push_dat (rx_data),
        .pop      (rx_pop),
        .head_dat (rx_head),
        .count    (rx_count),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    // Read-data selection from pre-edge state; unmapped addresses read as zero.
    always_comb begin
        rd_mux = 32'h0;
        case (bus_addr)
            ADDR_DATA:   rd_mux = rx_empty ? 32'h0000_0100 : {24'h0, rx_head};
            ADDR_STATUS: rd_mux = {26'h0, rx_ovf, tx_ovf, rx_empty, rx_full, tx_empty, tx_full};
            ADDR_CTRL:   rd_mux = {30'h0, txe_irq_en, rx_irq_en};
            ADDR_LEVEL:  rd_mux = {16'h0, rx_lvl, tx_lvl};
            default:     rd_mux = 32'h0;
        endcase
    end

    // Registered read response; bus_rdata holds its last value between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_rvalid <= 1'b0;
            bus_rdata  <= 32'h0;
        end else begin
            bus_rvalid <= rd_req;
            if (rd_req) begin
                bus_rdata <= rd_mux;
            end
        end
    end

    // Sticky overflow flags: write-1-to-clear, with a same-cycle set taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            tx_ovf <= tx_ovf_set | (tx_ovf & ~(ovf_clr_wr & bus_wdata[4]));
            rx_ovf <= rx_ovf_set | (rx_ovf & ~(ovf_clr_wr & bus_wdata[5]));
        end
    end

    // Interrupt enable register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_irq_en  <= 1'b0;
            txe_irq_en <= 1'b0;
        end else if (wr_req && bus_addr == ADDR_CTRL) begin
            rx_irq_en  <= bus_wdata[0];
            txe_irq_en <= bus_wdata[1];
        end
    end
endmodule

// File: tb/tb_uart_mmio.sv
// Randomized and directed stimulus for uart_mmio, checked every cycle against a queue-based model.
// Latency: inputs applied on the falling edge, outputs compared on the following falling edge.
// Backpressure: tx_ready and rx_valid are driven from bench-held levels so FIFOs can be filled and drained.
module tb_uart_mmio;
    localparam int D = 16;

    logic        clk;
    logic        rst;
    logic        bus_valid;
    logic        bus_write;
    logic [3:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        irq;

    uart_mmio #(.FIFO_DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_valid  (bus_valid),
        .bus_write  (bus_write),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic        m_tx_ovf;
    logic        m_rx_ovf;
    logic [1:0]  m_ctrl;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    // Levels held on the UART-side inputs across cycles
    logic        tx_rdy_h;
    logic        rx_vld_h;
    logic [7:0]  rx_dat_h;

    int n_chk;
    int n_pass;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock using the rules of the register map.
    task automatic model_step(input logic bv, input logic bw, input logic [3:0] a,
                              input logic [31:0] wd, input logic txr, input logic rxv,
                              input logic [7:0] rxd, input logic r);
        int          tn;
        int          rn;
        logic [31:0] rv;
        logic        rd;
        logic        wr;
        logic        tx_set;
        logic        rx_set;
        if (r) begin
            tx_q.delete();
            rx_q.delete();
            m_tx_ovf = 1'b0;
            m_rx_ovf = 1'b0;
            m_ctrl   = 2'b00;
            m_rvalid = 1'b0;
            m_rdata  = 32'h0;
        end else begin
            tn = tx_q.size();
            rn = rx_q.size();
            rd = bv && !bw;
            wr = bv && bw;
            case (a)
                4'h0:    rv = (rn > 0) ? {24'h0, rx_q[0]} : 32'h100;
                4'h4:    rv = {26'h0, m_rx_ovf, m_tx_ovf, 1'(rn == 0), 1'(rn == D),
                               1'(tn == 0), 1'(tn == D)};
                4'h8:    rv = {30'h0, m_ctrl};
                4'hC:    rv = {16'h0, 8'(rn), 8'(tn)};
                default: rv = 32'h0;
            endcase
            if (txr && tn > 0) void'(tx_q.pop_front());
            tx_set = wr && a == 4'h0 && tn == D;
            if (wr && a == 4'h0 && tn < D) tx_q.push_back(wd[7:0]);
            if (rd && a == 4'h0 && rn > 0) void'(rx_q.pop_front());
            rx_set = rxv && rn == D;
            if (rxv && rn < D) rx_q.push_back(rxd);
            if (wr && a == 4'h4) begin
                if (wd[4]) m_tx_ovf = 1'b0;
                if (wd[5]) m_rx_ovf = 1'b0;
            end
            if (tx_set) m_tx_ovf = 1'b1;
            if (rx_set) m_rx_ovf = 1'b1;
            if (wr && a == 4'h8) m_ctrl = wd[1:0];
            m_rvalid = rd;
            if (rd) m_rdata = rv;
        end
    endtask

    // One clock: drive inputs, update the model, then compare all outputs on the falling edge.
    task automatic cycle(input logic bv, input logic bw, input logic [3:0] a,
                         input logic [31:0] wd, input logic r);
        logic exp_irq;
        bus_valid = bv;
        bus_write = bw;
        bus_addr  = a;
        bus_wdata = wd;
        tx_ready  = tx_rdy_h;
        rx_valid  = rx_vld_h;
        rx_data   = rx_dat_h;
        rst       = r;
        model_step(bv, bw, a, wd, tx_rdy_h, rx_vld_h, rx_dat_h, r);
        @(posedge clk);
        @(negedge clk);
        exp_irq = (m_ctrl[0] && rx_q.size() > 0) || (m_ctrl[1] && tx_q.size() == 0);
        check_val("rvalid", 32'(bus_rvalid), 32'(m_rvalid));
        check_val("rdata", bus_rdata, m_rdata);
        check_val("tx_valid", 32'(tx_valid), 32'(tx_q.size() > 0));
        if (tx_q.size() > 0) check_val("tx_data", 32'(tx_data), 32'(tx_q[0]));
        check_val("rx_ready", 32'(rx_ready), 32'(rx_q.size() < D));
        check_val("irq", 32'(irq), 32'(exp_irq));
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [31:0] wd);
        cycle(1'b1, 1'b1, a, wd, 1'b0);
    endtask

    task automatic rd_reg(input logic [3:0] a);
        cycle(1'b1, 1'b0, a, 32'h0, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        tx_rdy_h = 1'b0;
        rx_vld_h = 1'b0;
        rx_dat_h = 8'h00;
        m_tx_ovf = 1'b0;
        m_rx_ovf = 1'b0;
        m_ctrl = 2'b00;
        m_rvalid = 1'b0;
        m_rdata = 32'h0;
        bus_valid = 1'b0; bus_write = 1'b0; bus_addr = 4'h0; bus_wdata = 32'h0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rst = 1'b1;

        // Reset state
        cycle(1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
        cycle(1'b1, 1'b0, 4'h4, 32'h0, 1'b1);
        check_val("rst_rvalid", 32'(bus_rvalid), 32'h0);
        check_val("rst_rx_ready", 32'(rx_ready), 32'h1);

        // Two TX bytes drain in order with LEVEL stepping 2,1,0
        wr_reg(4'h0, 32'h41);
        wr_reg(4'h0, 32'h42);
        check_val("tx_head_41", 32'(tx_data), 32'h41);
        tx_rdy_h = 1'b1;
        rd_reg(4'hC);
        check_val("lvl_2", bus_rdata, 32'h2);
        check_val("tx_head_42", 32'(tx_data), 32'h42);
        rd_reg(4'hC);
        check_val("lvl_1", bus_rdata, 32'h1);
        check_val("tx_drained", 32'(tx_valid), 32'h0);
        rd_reg(4'hC);
        check_val("lvl_0", bus_rdata, 32'h0);

        // TX overflow on the 17th byte, then write-1-to-clear
        tx_rdy_h = 1'b0;
        for (int i = 0; i < 17; i++) wr_reg(4'h0, 32'(8'h80 + i));
        rd_reg(4'h4);
        check_val("status_tx_ovf", bus_rdata, 32'h19);
        wr_reg(4'h4, 32'h10);
        rd_reg(4'h4);
        check_val("status_ovf_clr", bus_rdata, 32'h09);
        tx_rdy_h = 1'b1;
        for (int i = 0; i < D; i++) idle();
        tx_rdy_h = 1'b0;

        // RX single byte, then empty read
        rx_vld_h = 1'b1; rx_dat_h = 8'h55;
        idle();
        rx_vld_h = 1'b0;
        rd_reg(4'h0);
        check_val("rx_55", bus_rdata, 32'h55);
        rd_reg(4'h0);
        check_val("rx_empty_rd", bus_rdata, 32'h100);

        // RX fill with a held byte, overflow, then release by one pop
        rx_vld_h = 1'b1;
        for (int i = 0; i < D; i++) begin
            rx_dat_h = 8'(8'h60 + i);
            idle();
        end
        rx_dat_h = 8'hA5;
        idle();
        check_val("rx_full_rdy", 32'(rx_ready), 32'h0);
        rd_reg(4'h4);
        check_val("status_rx_ovf", 32'(bus_rdata[5]), 32'h1);
        rd_reg(4'h0);
        check_val("rx_first", bus_rdata, 32'h60);
        check_val("rx_rdy_after_pop", 32'(rx_ready), 32'h1);
        idle();
        check_val("rx_held_taken", 32'(rx_ready), 32'h0);
        rx_vld_h = 1'b0;
        rd_reg(4'hC);
        check_val("rx_lvl_16", bus_rdata, 32'h1000);
        for (int i = 0; i < D; i++) rd_reg(4'h0);
        check_val("rx_last_held", bus_rdata, 32'hA5);
        wr_reg(4'h4, 32'h30);

        // Interrupt enables
        wr_reg(4'h8, 32'h1);
        check_val("irq_rx_empty", 32'(irq), 32'h0);
        rx_vld_h = 1'b1; rx_dat_h = 8'h77;
        idle();
        rx_vld_h = 1'b0;
        check_val("irq_rx_data", 32'(irq), 32'h1);
        rd_reg(4'h0);
        check_val("irq_rx_popped", 32'(irq), 32'h0);
        wr_reg(4'h8, 32'h2);
        check_val("irq_tx_empty", 32'(irq), 32'h1);

        // Reset with both FIFOs half full and flags set
        for (int i = 0; i < 17; i++) wr_reg(4'h0, 32'(i));
        tx_rdy_h = 1'b1;
        for (int i = 0; i < 8; i++) idle();
        tx_rdy_h = 1'b0;
        rx_vld_h = 1'b1;
        for (int i = 0; i < 17; i++) begin
            rx_dat_h = 8'(i);
            idle();
        end
        rx_vld_h = 1'b0;
        for (int i = 0; i < 8; i++) rd_reg(4'h0);
        wr_reg(4'h8, 32'h3);
        check_val("pre_rst_irq", 32'(irq), 32'h1);
        tx_rdy_h = 1'b1; rx_vld_h = 1'b1;
        cycle(1'b1, 1'b0, 4'h4, 32'h0, 1'b1);
        tx_rdy_h = 1'b0; rx_vld_h = 1'b0;
        check_val("rst2_rvalid", 32'(bus_rvalid), 32'h0);
        check_val("rst2_rdata", bus_rdata, 32'h0);
        check_val("rst2_tx_valid", 32'(tx_valid), 32'h0);
        check_val("rst2_rx_ready", 32'(rx_ready), 32'h1);
        check_val("rst2_irq", 32'(irq), 32'h0);
        rd_reg(4'hC);
        check_val("rst2_level", bus_rdata, 32'h0);
        rd_reg(4'h4);
        check_val("rst2_status", bus_rdata, 32'h0A);

        // Randomized traffic with a per-segment bias toward filling or draining
        for (int seg = 0; seg < 8; seg++) begin
            int bias;
            bias = int'($urandom_range(0, 3));
            for (int i = 0; i < 400; i++) begin
                logic        bv;
                logic        bw;
                logic [3:0]  a;
                logic [31:0] wd;
                logic        r;
                bv = ($urandom_range(0, 9) < 6);
                bw = (bias == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
                if ($urandom_range(0, 7) == 0) a = 4'($urandom_range(0, 15));
                else                           a = 4'(4 * $urandom_range(0, 3));
                if (bias == 0 && $urandom_range(0, 1) == 1) a = 4'h0;
                wd = $urandom;
                r  = ($urandom_range(0, 299) == 0);
                tx_rdy_h = (bias == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
                rx_vld_h = (bias == 1) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
                rx_dat_h = 8'($urandom);
                cycle(bv, bw, a, wd, r);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
